alu_share_arbiter: RTL and testbench

//  Shares the single combinational ALU between NUM_REQ requesters (e.g. execute stage, address/branch unit).

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 36 +++
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter.
//   - ALU control code constants for the operations the ALU implements
//   - alu_code_supported(): 1 when a control code is implemented by the ALU
//   - arb_state_e: arbiter FSM states
package alu_pkg;

   localparam logic [3:0] ALU_SLL = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   function automatic logic alu_code_supported(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_ADD) || (code == ALU_SUB) ||
             (code == ALU_SLT) || (code == ALU_XOR);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        in   N    request vector
//   ptr        in   IW   highest-priority index this round
//   grant      out  N    one-hot grant (zero when no request)
//   grant_idx  out  IW   index of the granted request (0 when none)
//   grant_any  out  1    some request was granted
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   int idx;

   // Walk ptr, ptr+1, ... (mod N); the first request found wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters.
// One operation in flight; round-robin selection; operands and result registered.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. req_ready is only offered in IDLE to the arbitration winner; resp_valid
// is held for the granted requester until its resp_ready is seen high.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester operation handshake
//   req_op1/req_op2/req_ctrl    packed per-requester operands and control code
//   resp_valid/resp_ready       per-requester result handshake
//   resp_data/resp_err          shared result and unsupported-code flag
//   alu_inp1/alu_inp2/alu_control/alu_result   ALU connection
//   busy                        high whenever the FSM is not in IDLE
//   state_dbg                   current FSM state
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*XLEN-1:0] req_op1,
   input  logic [NUM_REQ*XLEN-1:0] req_op2,
   input  logic [NUM_REQ*4-1:0]    req_ctrl,
   output logic [NUM_REQ-1:0]      resp_valid,
   input  logic [NUM_REQ-1:0]      resp_ready,
   output logic [XLEN-1:0]         resp_data,
   output logic                    resp_err,
   output logic [XLEN-1:0]         alu_inp1,
   output logic [XLEN-1:0]         alu_inp2,
   output logic [3:0]              alu_control,
   input  logic [XLEN-1:0]         alu_result,
   output logic                    busy,
   output arb_state_e              state_dbg
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e          state, state_nxt;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       gnt_id;
   logic [XLEN-1:0]     op1_q, op2_q, resp_data_q;
   logic [3:0]          ctrl_q;
   logic                resp_err_q;

   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       grant_idx;
   logic                grant_any;
   logic                accept;
   logic                resp_hs;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // rst_n gates req_ready so nothing is offered while reset is held.
   assign req_ready   = (state == IDLE && rst_n) ? grant : '0;
   assign accept      = (state == IDLE) && grant_any;
   assign resp_hs     = (state == RESP) && resp_ready[gnt_id];

   assign alu_inp1    = op1_q;
   assign alu_inp2    = op2_q;
   assign alu_control = ctrl_q;
   assign resp_data   = resp_data_q;
   assign resp_err    = resp_err_q;
   assign busy        = (state != IDLE);
   assign state_dbg   = state;

   always_comb begin
      resp_valid = '0;
      if (state == RESP) resp_valid[gnt_id] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)  state_nxt = EXEC;
         EXEC:                 state_nxt = RESP;
         RESP:    if (resp_hs) state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         gnt_id      <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         ctrl_q      <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op1_q  <= req_op1[grant_idx*XLEN +: XLEN];
            op2_q  <= req_op2[grant_idx*XLEN +: XLEN];
            ctrl_q <= req_ctrl[grant_idx*4 +: 4];
            gnt_id <= grant_idx;
         end
         if (state == EXEC) begin
            resp_data_q <= alu_result;
            resp_err_q  <= !alu_code_supported(ctrl_q);
         end
         // The requester just served drops to lowest priority.
         if (resp_hs) begin
            rr_ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

   localparam int N = 4;
   localparam int XLEN = 32;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  ctrl;
   } op_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
   logic [N*XLEN-1:0] req_op1, req_op2;
   logic [N*4-1:0]    req_ctrl;
   logic [XLEN-1:0]   resp_data, alu_inp1, alu_inp2, alu_result;
   logic              resp_err, busy;
   logic [3:0]        alu_control;
   alu_pkg::arb_state_e state_dbg;

   alu_share_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_control(alu_control),
      .alu_result(alu_result), .busy(busy), .state_dbg(state_dbg)
   );

   // Reference ALU: implemented codes, anything else passes op1 through.
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      case (c)
         4'b0001: return a << b[4:0];
         4'b0010: return a + b;
         4'b0100: return a - b;
         4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0110: return a ^ b;
         default: return a;
      endcase
   endfunction

   always_comb alu_result = alu_ref(alu_inp1, alu_inp2, alu_control);

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- driver state ----------------
   op_t         src_q[N][$];
   logic [N-1:0] hs_seen = '0;
   int          hold_resp[N];
   bit          drop_mode = 0;
   bit          rr_rand = 0;

   // ---------------- model / scoreboard ----------------
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   int          grant_log[$];
   int          m_phase = 0;    // 0 free, 1 operation in ALU, 2 result offered
   int          m_ptr = 0;
   int          m_gnt = 0;
   logic [31:0] m_op1, m_op2;
   logic [3:0]  m_ctrl;
   logic [31:0] last_data[N];
   logic        last_err[N];
   int          accept_cyc = 0;
   int          rv_rise_cyc = 0;
   bit          rv_prev = 0;
   int          stall_cnt = 0;
   int          rv_count = 0;

   always @(negedge clk) begin : mon
      logic [N-1:0] e_ready, e_rv;
      int sel;
      cyc++;
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_resp_data", resp_data, 32'd0);
         chk("rst_resp_err", 32'(resp_err), 32'd0);
         chk("rst_alu_inp1", alu_inp1, 32'd0);
         chk("rst_alu_inp2", alu_inp2, 32'd0);
         chk("rst_alu_control", 32'(alu_control), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         m_phase = 0;
         m_ptr = 0;
         exp_q.delete();
         exp_err_q.delete();
         hs_seen = '0;
         rv_prev = 0;
      end else begin
         e_ready = '0;
         e_rv = '0;
         sel = -1;
         if (m_phase == 0) begin
            for (int k = 0; k < N; k++)
               if (sel < 0 && req_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            if (sel >= 0) e_ready[sel] = 1'b1;
         end
         if (m_phase == 2) e_rv[m_gnt] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("resp_valid", 32'(resp_valid), 32'(e_rv));
         chk("busy", 32'(busy), 32'(m_phase != 0));
         if (m_phase != 0) begin
            chk("alu_inp1", alu_inp1, m_op1);
            chk("alu_inp2", alu_inp2, m_op2);
            chk("alu_control", 32'(alu_control), 32'(m_ctrl));
         end
         if (m_phase == 2 && exp_q.size() > 0) begin
            chk("resp_data", resp_data, exp_q[0]);
            chk("resp_err", 32'(resp_err), 32'(exp_err_q[0]));
         end
         if (|resp_valid && !rv_prev) rv_rise_cyc = cyc;
         rv_prev = |resp_valid;
         if (resp_valid[1] && req_ready == '0 && busy) stall_cnt++;
         if (|resp_valid) rv_count++;

         // advance the model with the inputs the next rising edge will see
         hs_seen = req_valid & e_ready;
         if (m_phase == 0) begin
            if (sel >= 0) begin
               m_gnt  = sel;
               m_op1  = req_op1[sel*32 +: 32];
               m_op2  = req_op2[sel*32 +: 32];
               m_ctrl = req_ctrl[sel*4 +: 4];
               exp_q.push_back(alu_ref(m_op1, m_op2, m_ctrl));
               exp_err_q.push_back(!(m_ctrl inside {4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110}));
               grant_log.push_back(sel);
               accept_cyc = cyc;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (resp_ready[m_gnt]) begin
            last_data[m_gnt] = resp_data;
            last_err[m_gnt] = resp_err;
            if (exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               void'(exp_err_q.pop_front());
            end
            m_ptr = (m_gnt + 1) % N;
            m_phase = 0;
         end
      end
   end

   // ---------------- driver ----------------
   initial begin
      req_valid = '0;
      req_op1 = '0;
      req_op2 = '0;
      req_ctrl = '0;
      resp_ready = '0;
      for (int i = 0; i < N; i++) hold_resp[i] = 0;
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            req_valid[i] = drop_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            req_op1[i*32 +: 32] = src_q[i][0].op1;
            req_op2[i*32 +: 32] = src_q[i][0].op2;
            req_ctrl[i*4 +: 4] = src_q[i][0].ctrl;
         end else begin
            req_valid[i] = 1'b0;
         end
         if (hold_resp[i] > 0) begin
            resp_ready[i] = 1'b0;
            hold_resp[i]--;
         end else begin
            resp_ready[i] = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c);
      op_t o;
      o.op1 = a;
      o.op2 = b;
      o.ctrl = c;
      src_q[i].push_back(o);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      bit pending = 1;
      while (pending && n < budget) begin
         @(negedge clk);
         #2;
         n++;
         pending = (m_phase != 0);
         for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1;
      end
      chk("drain_timeout", 32'(pending), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_one(input string name, input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] c,
                          input logic [31:0] ed, input logic ee);
      push_op(i, a, b, c);
      drain(50);
      chk({name, "_data"}, last_data[i], ed);
      chk({name, "_err"}, 32'(last_err[i]), 32'(ee));
   endtask

   // ---------------- test sequence ----------------
   logic [3:0] good_codes[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110};

   initial begin : main
      int base;
      int n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // single ADD and its latency
      run_one("add_5_7", 0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
      chk("latency", 32'(rv_rise_cyc - accept_cyc), 32'd2);

      // contention: req0 first, then req1, next tie back to req0
      do_reset();
      base = grant_log.size();
      push_op(0, 32'd10, 32'd3, 4'b0100);
      push_op(1, 32'hF0, 32'h0F, 4'b0110);
      drain(50);
      chk("cont_first", 32'(grant_log[base]), 32'd0);
      chk("cont_second", 32'(grant_log[base+1]), 32'd1);
      chk("cont_sub", last_data[0], 32'd7);
      chk("cont_xor", last_data[1], 32'hFF);
      push_op(0, 32'd1, 32'd1, 4'b0010);
      push_op(1, 32'd2, 32'd2, 4'b0010);
      drain(50);
      chk("cont_tie_again", 32'(grant_log[base+2]), 32'd0);

      // backpressure on requester 1 while requester 0 waits
      stall_cnt = 0;
      hold_resp[1] = 10;
      push_op(1, 32'd100, 32'd23, 4'b0010);
      push_op(0, 32'd4, 32'd4, 4'b0110);
      drain(80);
      chk("stall_cycles_ge5", 32'(stall_cnt >= 5), 32'd1);
      chk("stall_result", last_data[1], 32'd123);

      // unsupported code and other operations
      run_one("unsup", 0, 32'hDEAD, 32'd5, 4'b1111, 32'hDEAD, 1'b1);
      run_one("slt", 0, 32'd3, 32'd9, 4'b0101, 32'd1, 1'b0);
      run_one("sll", 0, 32'd1, 32'd4, 4'b0001, 32'd16, 1'b0);
      run_one("slt_neg", 2, 32'hFFFF_FFFF, 32'd0, 4'b0101, 32'd1, 1'b0);

      // reset during EXEC: no response afterwards
      push_op(0, 32'd1, 32'd2, 4'b0010);
      n = 0;
      while (m_phase != 1 && n < 20) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("exec_reached", 32'(m_phase), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_alu_inp1", alu_inp1, 32'd0);
      chk("midrst_resp_data", resp_data, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rv_count = 0;
      repeat (8) @(negedge clk);
      chk("no_stale_resp", 32'(rv_count), 32'd0);

      // rotation with all four requesters valid
      do_reset();
      base = grant_log.size();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++)
            push_op(i, $urandom, $urandom, good_codes[$urandom_range(0, 4)]);
      drain(200);
      for (int k = 0; k < 12; k++) chk($sformatf("rot_%0d", k), 32'(grant_log[base+k]), 32'(k % N));

      // randomized traffic with dropped valids and random resp_ready
      drop_mode = 1;
      rr_rand = 1;
      for (int t = 0; t < 300; t++)
         push_op($urandom_range(0, N - 1),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 4'($urandom_range(0, 15)));
      drain(20000);
      drop_mode = 0;
      rr_rand = 0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
